// File: rtl/ps2_host_tx_if.sv
// Command-side interface of the PS/2 host transmitter.
//
// Handshake: the requester raises tx_start for exactly one cycle with
// tx_data valid in that same cycle. The transmitter accepts it only while
// idle (tx_busy low); a request made while tx_busy is high is dropped, not
// queued. Once a request is accepted, tx_busy stays high until exactly one
// of tx_done or tx_err pulses for one cycle. In that pulse cycle tx_busy is
// already low, and a new tx_start in the following cycle is accepted.
interface ps2_host_tx_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;

   modport master (output tx_start, output tx_data,
                   input  tx_busy,  input  tx_done, input tx_err);

   modport slave  (input  tx_start, input  tx_data,
                   output tx_busy,  output tx_done, output tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
// shifts one byte plus odd parity out on device clock edges, checks the ACK.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int START_TIMEOUT  = 1500000,
   parameter int XFER_TIMEOUT   = 200000
) (
   input  logic            clk,
   input  logic            rst,
   ps2_host_tx_if.slave    cmd,
   input  logic            ps2_clk_in,
   input  logic            ps2_data_in,
   output logic            ps2_clk_oe,
   output logic            ps2_data_oe,
   output logic [2:0]      state_dbg
);

   localparam int MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
   localparam int MAX_ALL = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
   localparam int CW      = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_RTS       = 3'd2,
      S_REQ       = 3'd3,
      S_SHIFT     = 3'd4,
      S_WAIT_IDLE = 3'd5,
      S_DONE      = 3'd6,
      S_ERR       = 3'd7
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [3:0]    nbit, nbit_n;
   logic          doe_q, doe_n;
   logic [7:0]    byte_q, byte_n;
   logic          par_q, par_n;

   logic clk_s1, clk_s2, clk_prev;
   logic data_s1, data_s2;
   logic fall;

   // Two-flop synchronizers for the open-drain pins plus a delayed clock copy
   // for edge detection; idle bus level is high, so reset to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk_in;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data_in;
         data_s2  <= data_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   // Saturating increment so no timeout counter can ever wrap.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         nbit   <= '0;
         doe_q  <= 1'b0;
         byte_q <= '0;
         par_q  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         nbit   <= nbit_n;
         doe_q  <= doe_n;
         byte_q <= byte_n;
         par_q  <= par_n;
      end
   end

   // Next-state logic; nbit holds the number of device falling edges seen.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      nbit_n  = nbit;
      doe_n   = doe_q;
      byte_n  = byte_q;
      par_n   = par_q;
      case (state)
         S_IDLE: begin
            cnt_n  = '0;
            nbit_n = '0;
            doe_n  = 1'b0;
            if (cmd.tx_start) begin
               byte_n  = cmd.tx_data;
               par_n   = ~^cmd.tx_data;
               state_n = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt == INH_LAST) begin
               cnt_n   = '0;
               state_n = S_RTS;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         S_RTS: begin
            cnt_n   = '0;
            doe_n   = 1'b1;
            state_n = S_REQ;
         end
         S_REQ: begin
            if (fall) begin
               nbit_n  = 4'd1;
               doe_n   = ~byte_q[0];
               cnt_n   = '0;
               state_n = S_SHIFT;
            end else if (cnt == START_LAST) begin
               state_n = S_ERR;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         S_SHIFT: begin
            if (fall) begin
               // This edge is number nbit+1.
               nbit_n = nbit + 4'd1;
               if (nbit <= 4'd7) begin
                  doe_n = ~byte_q[nbit[2:0]];
               end else if (nbit == 4'd8) begin
                  doe_n = ~par_q;
               end else if (nbit == 4'd9) begin
                  doe_n = 1'b0;
               end else begin
                  doe_n   = 1'b0;
                  cnt_n   = '0;
                  state_n = data_s2 ? S_ERR : S_WAIT_IDLE;
               end
            end else if (cnt == XFER_LAST) begin
               state_n = S_ERR;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         S_WAIT_IDLE: begin
            doe_n = 1'b0;
            if (clk_s2 && data_s2) begin
               state_n = S_DONE;
            end else if (cnt == XFER_LAST) begin
               state_n = S_ERR;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         default: begin
            cnt_n   = '0;
            nbit_n  = '0;
            doe_n   = 1'b0;
            state_n = S_IDLE;
         end
      endcase
   end

   // Pin enables and status decoded from state.
   always_comb begin
      ps2_clk_oe  = (state == S_INHIBIT) || (state == S_RTS);
      ps2_data_oe = 1'b0;
      if ((state == S_RTS) || (state == S_REQ)) begin
         ps2_data_oe = 1'b1;
      end else if (state == S_SHIFT) begin
         ps2_data_oe = doe_q;
      end
   end

   assign cmd.tx_busy = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
   assign cmd.tx_done = (state == S_DONE);
   assign cmd.tx_err  = (state == S_ERR);
   assign state_dbg   = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and compares each sampled bit against a frame model.
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int ST   = 300;
   localparam int XT   = 2000;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic [2:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   logic [0:0] exp_q[$];

   ps2_host_tx_if cmd_if ();

   // Open-drain bus: either side can pull a line low.
   assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .START_TIMEOUT  (ST),
      .XFER_TIMEOUT   (XT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd         (cmd_if.slave),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .state_dbg   (state_dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   // Pulse counters.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_if.tx_done) done_cnt++;
         if (cmd_if.tx_err)  err_cnt++;
      end
   end

   // Global time limit.
   initial begin
      #(3_000_000);
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Odd parity: the parity bit makes the total count of ones odd.
   function automatic logic model_parity(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += b[i];
      return (ones % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   // Expected line levels seen by the device: 8 data bits LSB first, parity, stop.
   task automatic push_frame(input logic [7:0] b);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(model_parity(b));
      exp_q.push_back(1'b1);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      @(negedge clk);
      cmd_if.tx_data  = b;
      cmd_if.tx_start = 1'b1;
      @(negedge clk);
      cmd_if.tx_start = 1'b0;
   endtask

   // Wait for request-to-send as seen on the pins; returns cycles waited.
   task automatic wait_req(output int w);
      w = 0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check("rts_seen", (w < 4000), 1);
   endtask

   // Device: mode 0 = ACK, 1 = no ACK, 2 = reset host after edge 5.
   task automatic dev_run(input int mode);
      int         w;
      logic [0:0] e;
      wait_req(w);
      if (w >= 4000) return;
      repeat (10) @(negedge clk);
      for (int k = 1; k <= 11; k++) begin
         dev_clk = 1'b0;
         if (mode == 2 && k == 5) begin
            repeat (6) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("abort_clk_oe", ps2_clk_oe, 0);
            check("abort_data_oe", ps2_data_oe, 0);
            check("abort_busy", cmd_if.tx_busy, 0);
            dev_clk = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            return;
         end
         repeat (HALF) @(negedge clk);
         if (k <= 10) begin
            if (exp_q.size() == 0) begin
               check("exp_q_underflow", 0, 1);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("bit%0d", k), ps2_data_in, e);
            end
         end
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clk);
         if (k == 10 && mode == 0) dev_data = 1'b0;
      end
      dev_data = 1'b1;
   endtask

   // Wait until the host goes idle, then compare pulse counts.
   task automatic finish_xfer(input string tag, input int d0, input int e0,
                              input int exp_d, input int exp_e);
      int w = 0;
      while (cmd_if.tx_busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_idle_bound"}, (w < 200), 1);
      repeat (3) @(negedge clk);
      check({tag, "_done_cnt"}, done_cnt - d0, exp_d);
      check({tag, "_err_cnt"}, err_cnt - e0, exp_e);
      check({tag, "_clk_oe"}, ps2_clk_oe, 0);
      check({tag, "_data_oe"}, ps2_data_oe, 0);
   endtask

   task automatic full_xfer(input string tag, input logic [7:0] b, input int mode);
      int d0 = done_cnt;
      int e0 = err_cnt;
      push_frame(b);
      send_cmd(b);
      dev_run(mode);
      finish_xfer(tag, d0, e0, (mode == 0) ? 1 : 0, (mode == 0) ? 0 : 1);
   endtask

   initial begin
      int         d0, e0, w, c;
      logic [7:0] rb;
      cmd_if.tx_start = 1'b0;
      cmd_if.tx_data  = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_busy", cmd_if.tx_busy, 0);
      check("rst_done", cmd_if.tx_done, 0);
      check("rst_err", cmd_if.tx_err, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 0xED with ACK; busy and bus inhibit must follow the accepted start.
      d0 = done_cnt;
      e0 = err_cnt;
      push_frame(8'hED);
      send_cmd(8'hED);
      check("busy_after_start", cmd_if.tx_busy, 1);
      check("inhibit_clk_oe", ps2_clk_oe, 1);
      check("inhibit_data_oe", ps2_data_oe, 0);
      dev_run(0);
      finish_xfer("ed", d0, e0, 1, 0);

      // Parity 0 and all-zero byte.
      full_xfer("x07", 8'h07, 0);
      full_xfer("x00", 8'h00, 0);

      // Random bytes.
      for (int i = 0; i < 4; i++) begin
         rb = 8'($urandom_range(0, 255));
         full_xfer($sformatf("rnd%0d", i), rb, 0);
      end

      // Device never clocks: error exactly START_TIMEOUT cycles after REQ entry.
      d0 = done_cnt;
      e0 = err_cnt;
      send_cmd(8'h55);
      wait_req(w);
      c = 0;
      while (!cmd_if.tx_err && c < ST + 100) begin
         @(negedge clk);
         c++;
      end
      check("start_timeout_cycles", c, ST);
      check("start_timeout_clk_oe", ps2_clk_oe, 0);
      check("start_timeout_data_oe", ps2_data_oe, 0);
      check("start_timeout_busy", cmd_if.tx_busy, 0);
      finish_xfer("noclk", d0, e0, 0, 1);

      // No ACK at edge 11.
      full_xfer("nack", 8'hA5, 1);

      // Reset during the shift, then a clean transfer.
      d0 = done_cnt;
      e0 = err_cnt;
      push_frame(8'h3C);
      send_cmd(8'h3C);
      dev_run(2);
      repeat (5) @(negedge clk);
      check("abort_done_cnt", done_cnt - d0, 0);
      check("abort_err_cnt", err_cnt - e0, 0);
      full_xfer("after_abort", 8'hC3, 0);

      // Second start during INHIBIT is ignored.
      d0 = done_cnt;
      e0 = err_cnt;
      push_frame(8'h96);
      send_cmd(8'h96);
      repeat (5) @(negedge clk);
      send_cmd(8'h18);
      dev_run(0);
      finish_xfer("dbl", d0, e0, 1, 0);
      check("dbl_exp_q_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
